// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes.
// The final sign fix-up is applied when the result is registered.
// Results leave through a registered valid/ready channel.
module alu_muldiv_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_LENGTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_LENGTH-1:0]  Op,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_hi;        // running high product half / partial remainder
    logic [W-1:0]   r_lo;        // multiplier being consumed / dividend-quotient shift reg
    logic [W-1:0]   r_b;         // |multiplicand| or |divisor|
    logic [2:0]     r_op;
    logic           r_neg_q;     // product or quotient must be negated
    logic           r_neg_r;     // remainder must be negated
    logic [W-1:0]   r_result;
    logic           r_out_valid;

    // Decoded view of the incoming request
    logic [2:0]     w_op;
    logic           w_is_div;
    logic           w_signed_a;
    logic           w_signed_b;
    logic           w_neg_a;
    logic           w_neg_b;
    logic [W-1:0]   w_mag_a;
    logic [W-1:0]   w_mag_b;
    logic           w_div_zero;
    logic           w_div_ovf;
    logic [W-1:0]   w_special_res;

    // One iteration of the datapath
    logic [W:0]     w_msum;
    logic [W:0]     w_shift;
    logic           w_ge;
    logic [W-1:0]   w_hi_next;
    logic [W-1:0]   w_lo_next;

    // Final result assembly from the last iteration
    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] w_prod_fin;
    logic [W-1:0]   w_quo_fin;
    logic [W-1:0]   w_rem_fin;
    logic [W-1:0]   w_calc_res;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign Result    = r_result;

    // Decode op signedness, operand magnitudes and the divide special cases
    always_comb begin
        w_op       = Op[2:0];
        w_is_div   = w_op[2];
        // MULHU, DIVU and REMU treat rs1 as unsigned
        w_signed_a = !((w_op == 3'b011) || (w_op[2] && w_op[0]));
        // rs2 is signed for MUL, MULH, DIV and REM only
        w_signed_b = w_op[2] ? !w_op[0] : !w_op[1];
        w_neg_a    = w_signed_a && SrcA[W-1];
        w_neg_b    = w_signed_b && SrcB[W-1];
        w_mag_a    = w_neg_a ? -SrcA : SrcA;
        w_mag_b    = w_neg_b ? -SrcB : SrcB;
        w_div_zero = w_is_div && (SrcB == '0);
        w_div_ovf  = w_is_div && !w_op[0] && (SrcA == MIN_NEG) && (SrcB == ALL_ONES);
        if (w_div_zero) begin
            w_special_res = w_op[1] ? SrcA : ALL_ONES;
        end else begin
            w_special_res = w_op[1] ? '0 : MIN_NEG;
        end
    end

    // Next value of the iteration registers: shift-add step or restoring-divide step
    always_comb begin
        w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_shift = {r_hi, r_lo[W-1]};
        w_ge    = (w_shift >= {1'b0, r_b});
        if (r_op[2]) begin
            // The partial remainder is always below the divisor, so W bits suffice
            w_hi_next = w_ge ? W'(w_shift - {1'b0, r_b}) : w_shift[W-1:0];
            w_lo_next = {r_lo[W-2:0], w_ge};
        end else begin
            w_hi_next = w_msum[W:1];
            w_lo_next = {w_msum[0], r_lo[W-1:1]};
        end
    end

    // Sign fix-up and half/quotient/remainder selection for the final iteration
    always_comb begin
        w_prod     = {w_hi_next, w_lo_next};
        w_prod_fin = r_neg_q ? -w_prod : w_prod;
        w_quo_fin  = r_neg_q ? -w_lo_next : w_lo_next;
        w_rem_fin  = r_neg_r ? -w_hi_next : w_hi_next;
        case (r_op)
            3'b000:                 w_calc_res = w_prod_fin[W-1:0];
            3'b001, 3'b010, 3'b011: w_calc_res = w_prod_fin[2*W-1:W];
            3'b100, 3'b101:         w_calc_res = w_quo_fin;
            default:                w_calc_res = w_rem_fin;
        endcase
    end

    // Control FSM with registered result and valid; flush overrides everything but reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op <= w_op;
                        if (w_div_zero || w_div_ovf) begin
                            // Result is known at accept; skip the iterations
                            r_result    <= w_special_res;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_neg_q <= w_neg_a ^ w_neg_b;
                            r_neg_r <= w_neg_a;
                            r_hi    <= '0;
                            r_lo    <= w_mag_a;
                            r_b     <= w_mag_b;
                            r_cnt   <= CW'(W);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_hi  <= w_hi_next;
                    r_lo  <= w_lo_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_result    <= w_calc_res;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq (DATA_WIDTH=32): directed vector table, flush/reset
// sequences and random operations checked against a 64-bit arithmetic model.
module tb_alu_muldiv_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   Op;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Result;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        int           lat;
        int           stall;
    } vec_t;

    vec_t vecs[15];

    always #5 clk = ~clk;

    alu_muldiv_seq #(
        .DATA_WIDTH(W),
        .OP_LENGTH (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Op       (Op),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Result   (Result)
    );

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h required=0x%08h", name, got, exp);
        end
    endtask

    // RISC-V M-extension semantics computed with 64-bit integers
    function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        longint          sa;
        longint          sb;
        longint          ub;
        longint          p;
        longint unsigned pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        pu = 64'd0;
        p  = 64'd0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Divides by zero and the signed-overflow divide finish right after accept
    function automatic int ref_latency(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 1;
        return W + 1;
    endfunction

    // Entered and left at a falling edge; one full accept/compute/handshake transaction
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, input int exp_lat, input int stall,
                         input string tag);
        int n;
        bit busy_bad;
        check({tag, " in_ready_idle"}, W'(in_ready), W'(1));
        Op       = op;
        SrcA     = a;
        SrcB     = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        Op       = 3'($urandom);
        SrcA     = $urandom;
        SrcB     = $urandom;
        n        = 1;
        busy_bad = 1'b0;
        while (!out_valid && n <= W + 10) begin
            if (in_ready) busy_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: out_valid=0 required=1 within %0d cycles", tag, n);
            return;
        end
        check({tag, " latency"}, W'(n), W'(exp_lat));
        check({tag, " in_ready_busy"}, W'(busy_bad | in_ready), W'(0));
        check({tag, " result"}, Result, exp_res);
        out_ready = 1'b0;
        repeat (stall) begin
            @(negedge clk);
            check({tag, " hold_result"}, Result, exp_res);
            check({tag, " hold_valid_ready"}, W'({out_valid, in_ready}), W'(2'b10));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " after_handshake"}, W'({out_valid, in_ready}), W'(2'b01));
        $display("%s op=%0d a=0x%08h b=0x%08h result=0x%08h latency=%0d", tag, op, a, b,
                 exp_res, n);
    endtask

    initial begin
        bit seen;
        logic [2:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0]  = '{3'd0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 33, 5};
        vecs[1]  = '{3'd1, 32'h80000000,  32'h80000000, 32'h40000000, 33, 0};
        vecs[2]  = '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1};
        vecs[4]  = '{3'd4, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 33, 0};
        vecs[5]  = '{3'd6, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 33, 0};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,        32'd14,       33, 0};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,        32'd2,        33, 0};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,        32'hFFFFFFFF, 1,  2};
        vecs[9]  = '{3'd6, 32'd5,         32'd0,        32'd5,        1,  0};
        vecs[10] = '{3'd4, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1,  0};
        vecs[11] = '{3'd6, 32'h80000000,  32'hFFFFFFFF, 32'd0,        1,  0};
        vecs[12] = '{3'd5, 32'h80000000,  32'hFFFFFFFF, 32'd0,        33, 0};
        vecs[13] = '{3'd7, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 33, 0};
        vecs[14] = '{3'd0, 32'h80000000,  32'h80000000, 32'd0,        33, 0};

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Op        = '0;
        SrcA      = '0;
        SrcB      = '0;
        repeat (3) @(negedge clk);
        check("reset out_valid", W'(out_valid), W'(0));
        check("reset result", Result, '0);
        check("reset in_ready", W'(in_ready), W'(1));
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors, issued back to back
        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, vecs[i].stall,
                  $sformatf("vec%0d", i));
        end

        // Flush during a divide ten cycles after accept
        Op       = 3'd4;
        SrcA     = 32'd100;
        SrcB     = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_calc in_ready", W'(in_ready), W'(1));
        check("flush_calc out_valid", W'(out_valid), W'(0));
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_calc no_output", W'(seen), W'(0));
        $display("flush during DIV: output suppressed");

        // Flush in IDLE blocks the accept in the same cycle
        Op       = 3'd3;
        SrcA     = 32'd3;
        SrcB     = 32'd5;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle in_ready", W'(in_ready), W'(1));
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_idle no_output", W'(seen), W'(0));
        $display("flush in IDLE: request not accepted");

        // Leave a nonzero Result behind, then reset asynchronously mid-calculation
        do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0, "pre_reset");
        Op       = 3'd0;
        SrcA     = 32'd7;
        SrcB     = 32'd9;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_calc in_ready", W'(in_ready), W'(0));
        #1 reset = 1'b1;
        #1;
        check("async_reset out_valid", W'(out_valid), W'(0));
        check("async_reset result", Result, '0);
        check("async_reset in_ready", W'(in_ready), W'(1));
        @(negedge clk);
        reset = 1'b0;
        $display("async reset during MUL: outputs cleared");
        do_op(3'd3, 32'd3, 32'd5, 32'd0, 33, 0, "post_reset");

        // Random operations against the arithmetic model
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'($urandom_range(0, 255));
                default: ;
            endcase
            do_op(rop, ra, rb, ref_result(rop, ra, rb), ref_latency(rop, ra, rb),
                  $urandom_range(0, 2), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
